aesl_deadlock_confirm_unit: RTL and testbench

//  Downstream consumer of the per-process deadlock detect units' dl_detect_out vector.

---
 rtl/aesl_deadlock_confirm_unit.sv | 132 +++++++++++++
 tb/tb_aesl_deadlock_confirm_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aesl_deadlock_confirm_unit.sv
// Confirms a dataflow deadlock by requiring one origin process's suspect flag to persist.
// Optional macro AESL_DL_TRANS_CHECK_EN rejects confirmations with no pending transactions.
module aesl_deadlock_confirm_unit #(
  parameter int unsigned PROC_NUM       = 2,
  parameter int unsigned CONFIRM_CYCLES = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned IDX_W          = 1
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic                all_finish,
  input  logic [CNT_W-1:0]    trans_in_cnt,
  input  logic [CNT_W-1:0]    trans_out_cnt,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_detect_out,
  output logic                dl_report_vld,
  output logic [IDX_W-1:0]    dl_report_proc,
  output logic [CNT_W-1:0]    dl_pending_trans
);

  localparam int unsigned PCNT_W = $clog2(CONFIRM_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_CLEAR,
    S_DETECTED
  } state_e;

  state_e              state_q;
  logic [PCNT_W-1:0]   cnt_q;
  logic [PROC_NUM-1:0] origin_q;
  logic [IDX_W-1:0]    origin_idx_q;
  logic                token_clear_q;
  logic                detect_q;
  logic                report_vld_q;
  logic [IDX_W-1:0]    report_proc_q;
  logic [CNT_W-1:0]    pending_q;

  logic [PROC_NUM-1:0] susp_c;
  logic [PROC_NUM-1:0] first_c;
  logic [IDX_W-1:0]    first_idx_c;
  logic [CNT_W-1:0]    pending_c;
  logic                pend_ok_c;

  assign susp_c  = dl_in_vec & ~{PROC_NUM{all_finish}};
  // Two's-complement trick isolates the lowest set suspect bit.
  assign first_c = susp_c & (~susp_c + PROC_NUM'(1));

  always_comb begin
    logic found;
    found       = 1'b0;
    first_idx_c = '0;
    for (int i = 0; i < PROC_NUM; i++) begin
      if (susp_c[i] && !found) begin
        first_idx_c = IDX_W'(i);
        found       = 1'b1;
      end
    end
  end

`ifdef AESL_DL_TRANS_CHECK_EN
  assign pending_c = trans_in_cnt - trans_out_cnt;
  assign pend_ok_c = (pending_c != '0);
`else
  logic unused_trans;
  assign unused_trans = ^{trans_in_cnt, trans_out_cnt};
  assign pending_c    = '0;
  assign pend_ok_c    = 1'b1;
`endif

  always_ff @(posedge dl_clock) begin
    if (dl_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      origin_q      <= '0;
      origin_idx_q  <= '0;
      token_clear_q <= 1'b0;
      detect_q      <= 1'b0;
      report_vld_q  <= 1'b0;
      report_proc_q <= '0;
      pending_q     <= '0;
    end else begin
      token_clear_q <= 1'b0;
      report_vld_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|susp_c) begin
            origin_q     <= first_c;
            origin_idx_q <= first_idx_c;
            cnt_q        <= '0;
            state_q      <= S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          // Only the chosen origin's flag matters; a drop is a false alarm.
          if ((susp_c & origin_q) == '0) begin
            origin_q      <= '0;
            token_clear_q <= 1'b1;
            state_q       <= S_CLEAR;
          end else if (cnt_q == PCNT_W'(CONFIRM_CYCLES - 1)) begin
            if (pend_ok_c) begin
              state_q       <= S_DETECTED;
              detect_q      <= 1'b1;
              report_vld_q  <= 1'b1;
              report_proc_q <= origin_idx_q;
              pending_q     <= pending_c;
            end else begin
              origin_q      <= '0;
              token_clear_q <= 1'b1;
              state_q       <= S_CLEAR;
            end
          end else begin
            cnt_q <= cnt_q + PCNT_W'(1);
          end
        end
        S_CLEAR: state_q <= S_IDLE;
        default: ;
      endcase
    end
  end

  assign origin           = origin_q;
  assign token_clear      = token_clear_q;
  assign dl_detect_out    = detect_q;
  assign dl_report_vld    = report_vld_q;
  assign dl_report_proc   = report_proc_q;
  assign dl_pending_trans = pending_q;

endmodule

// File: tb/tb_aesl_deadlock_confirm_unit.sv
// Scoreboard bench: a stimulus table is scanned by a window-based reference model that
// predicts clear/report events and per-cycle origin/detect values.
module tb_aesl_deadlock_confirm_unit;

  localparam int C    = 4;
  localparam int MAXN = 4000;

  logic        dl_clock;
  logic        dl_reset;
  logic [1:0]  dl_in_vec;
  logic        all_finish;
  logic [15:0] trans_in_cnt;
  logic [15:0] trans_out_cnt;
  logic [1:0]  origin;
  logic        token_clear;
  logic        dl_detect_out;
  logic        dl_report_vld;
  logic [0:0]  dl_report_proc;
  logic [15:0] dl_pending_trans;

  aesl_deadlock_confirm_unit #(
    .PROC_NUM(2), .CONFIRM_CYCLES(C), .CNT_W(16), .IDX_W(1)
  ) dut (
    .dl_clock(dl_clock), .dl_reset(dl_reset), .dl_in_vec(dl_in_vec),
    .all_finish(all_finish), .trans_in_cnt(trans_in_cnt), .trans_out_cnt(trans_out_cnt),
    .origin(origin), .token_clear(token_clear), .dl_detect_out(dl_detect_out),
    .dl_report_vld(dl_report_vld), .dl_report_proc(dl_report_proc),
    .dl_pending_trans(dl_pending_trans)
  );

  initial dl_clock = 1'b0;
  always #5 dl_clock = ~dl_clock;

  typedef struct {
    int          cyc;
    bit          clr;
    int          proc;
    logic [15:0] pend;
  } ev_t;

  bit          r_rst [MAXN];
  logic [1:0]  r_vec [MAXN];
  bit          r_fin [MAXN];
  logic [15:0] r_tin [MAXN];
  logic [15:0] r_tout[MAXN];
  logic [1:0]  e_org [MAXN];
  bit          e_det [MAXN];
  int          n;
  ev_t         evs[$];
  ev_t         sb[$];
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [1:0] vec, input bit fin,
                     input logic [15:0] tin, input logic [15:0] tout, input int len);
    for (int k = 0; k < len; k++) begin
      if (n < MAXN) begin
        r_rst[n] = rst; r_vec[n] = vec; r_fin[n] = fin;
        r_tin[n] = tin; r_tout[n] = tout;
        n++;
      end
    end
  endtask

  function automatic logic [1:0] susp(input int i);
    return r_vec[i] & ~{2{r_fin[i]}};
  endfunction

  // Each suspicion window starting in idle needs C further samples of the origin flag.
  task automatic build_model();
    int j, k, idx, p;
    bit det, done;
    int det_p;
    logic [1:0] s, oh;
    logic [15:0] pend;
    ev_t e;
    for (int i = 0; i < MAXN; i++) begin e_org[i] = 2'b00; e_det[i] = 1'b0; end
    j = 0; det = 1'b0; det_p = 0;
    while (j < n) begin
      if (r_rst[j]) begin det = 1'b0; j++; continue; end
      if (det) begin e_det[j] = 1'b1; e_org[j] = 2'b01 << det_p; j++; continue; end
      s = susp(j);
      if (s == 2'b00) begin j++; continue; end
      p = s[0] ? 0 : 1;
      oh = 2'b01 << p;
      e_org[j] = oh;
      k = 1; done = 1'b0;
      while (!done) begin
        idx = j + k;
        s = (idx < n) ? susp(idx) : 2'b00;
        if (idx >= n) begin
          j = n; done = 1'b1;
        end else if (r_rst[idx]) begin
          j = idx; done = 1'b1;
        end else if (s[p] == 1'b0) begin
          e = '{cyc: idx, clr: 1'b1, proc: 0, pend: 16'd0};
          evs.push_back(e);
          j = idx + 2; done = 1'b1;
        end else if (k == C) begin
`ifdef AESL_DL_TRANS_CHECK_EN
          pend = r_tin[idx] - r_tout[idx];
`else
          pend = 16'd0;
`endif
`ifdef AESL_DL_TRANS_CHECK_EN
          if (pend == 16'd0) begin
            e = '{cyc: idx, clr: 1'b1, proc: 0, pend: 16'd0};
            evs.push_back(e);
            j = idx + 2;
          end else
`endif
          begin
            e = '{cyc: idx, clr: 1'b0, proc: p, pend: pend};
            evs.push_back(e);
            det = 1'b1; det_p = p;
            e_det[idx] = 1'b1; e_org[idx] = oh;
            j = idx + 1;
          end
          done = 1'b1;
        end else begin
          e_org[idx] = oh; k++;
        end
      end
    end
  endtask

  task automatic build_stim();
    int r, len;
    logic [1:0] v;
    logic [15:0] tin, d;
    n = 0;
    add(1, 2'b11, 0, 16'd0, 16'd0, 3);
    add(0, 2'b00, 0, 16'd0, 16'd0, 1);
    add(0, 2'b10, 0, 16'd7, 16'd5, 6);
    add(0, 2'b00, 0, 16'd7, 16'd5, 3);
    add(1, 2'b00, 0, 16'd0, 16'd0, 1);
    add(0, 2'b11, 0, 16'd7, 16'd5, 6);
    add(1, 2'b00, 0, 16'd0, 16'd0, 1);
    add(0, 2'b01, 0, 16'd7, 16'd5, 2);
    add(0, 2'b00, 0, 16'd7, 16'd5, 3);
    add(0, 2'b01, 0, 16'd7, 16'd5, 6);
    add(1, 2'b00, 0, 16'd0, 16'd0, 1);
    add(0, 2'b01, 0, 16'd7, 16'd5, 2);
    add(0, 2'b01, 1, 16'd7, 16'd5, 3);
    add(0, 2'b00, 0, 16'd7, 16'd5, 2);
    add(0, 2'b01, 0, 16'd5, 16'd5, 6);
    add(0, 2'b00, 0, 16'd5, 16'd5, 2);
    add(0, 2'b01, 0, 16'd7, 16'd5, 6);
    add(1, 2'b00, 0, 16'd0, 16'd0, 1);
    add(0, 2'b01, 0, 16'd1, 16'hFFFF, 6);
    add(1, 2'b00, 0, 16'd0, 16'd0, 1);
    for (int s = 0; s < 250; s++) begin
      r   = $urandom_range(0, 9);
      v   = 2'($urandom_range(0, 3));
      tin = 16'($urandom);
      d   = 16'($urandom_range(0, 2));
      if (r == 0)      add(1, v, 0, tin, tin - d, $urandom_range(1, 3));
      else if (r == 1) add(0, v, 1, tin, tin - d, $urandom_range(1, 4));
      else             add(0, v, 0, tin, tin - d, $urandom_range(1, 7));
    end
    add(0, 2'b00, 0, 16'd0, 16'd0, C + 4);
  endtask

  initial begin
    checks = 0; errors = 0;
    dl_reset = 1'b1; dl_in_vec = 2'b00; all_finish = 1'b0;
    trans_in_cnt = 16'd0; trans_out_cnt = 16'd0;
    build_stim();
    build_model();
    fork
      begin : driver
        int ei;
        ei = 0;
        for (int j = 0; j < n; j++) begin
          dl_reset = r_rst[j]; dl_in_vec = r_vec[j]; all_finish = r_fin[j];
          trans_in_cnt = r_tin[j]; trans_out_cnt = r_tout[j];
          while (ei < evs.size() && evs[ei].cyc == j) begin
            sb.push_back(evs[ei]);
            ei++;
          end
          @(negedge dl_clock);
        end
      end
      begin : monitor
        ev_t e;
        for (int j = 0; j < n; j++) begin
          @(posedge dl_clock);
          @(negedge dl_clock);
          while (sb.size() > 0 && sb[0].cyc < j) begin
            e = sb.pop_front();
            chk($sformatf("missing_event@%0d", e.cyc), 32'd0, 32'd1);
          end
          if (r_rst[j]) begin
            chk($sformatf("reset_outputs@%0d", j),
                32'({origin, token_clear, dl_detect_out, dl_report_vld, dl_report_proc, dl_pending_trans}), 32'd0);
          end else begin
            chk($sformatf("origin@%0d", j), 32'(origin), 32'(e_org[j]));
            chk($sformatf("detect@%0d", j), 32'(dl_detect_out), 32'(e_det[j]));
          end
          if (token_clear || dl_report_vld) begin
            if (sb.size() == 0) begin
              chk($sformatf("unexpected_event@%0d", j), {30'd0, token_clear, dl_report_vld}, 32'd0);
            end else begin
              e = sb.pop_front();
              chk($sformatf("event_cycle@%0d", j), 32'(j), 32'(e.cyc));
              chk($sformatf("event_kind@%0d", j), {30'd0, token_clear, dl_report_vld},
                  e.clr ? 32'd2 : 32'd1);
              if (!e.clr) begin
                chk($sformatf("report_proc@%0d", j), 32'(dl_report_proc), 32'(e.proc));
                chk($sformatf("pending_trans@%0d", j), 32'(dl_pending_trans), 32'(e.pend));
              end
            end
          end
        end
      end
    join
    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      chk($sformatf("missing_event@%0d", e.cyc), 32'd0, 32'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
